aes_block_gearbox: RTL
======================

// Module: aes_block_gearbox
// PURPOSE
//  Word-serial front/back end for the AES core in sim_bench. Packs WORDS x WORD_W input words
//  into one block and offers it to the core over a valid/ready handshake. Captures the core's
//  result block and replays it as words. One block in flight at a time.
// PARAMETERS
//  WORD_W   32  width of one serial word
//  WORDS    4   words per block; BLK_W = WORD_W*WORDS (128 for AES)
//  CNT_W    16  width of the completed-block counter
// PORTS
//  clk           in   1          single clock; every flop is on clk
//  rst_n         in   1          reset, asynchronous and active-low
//  s_word        in   WORD_W     input word
//  s_valid       in   1          input word valid
//  s_ready       out  1          gearbox accepts s_word this cycle
//  aes_in_block  out  BLK_W      packed block to AES core
//  aes_in_valid  out  1          aes_in_block valid
//  aes_in_ready  in   1          core accepts block
//  aes_out_block in   BLK_W      result block from core
//  aes_out_valid in   1          result valid
//  aes_out_ready out  1          gearbox accepts result
//  m_word        out  WORD_W     output word
//  m_valid       out  1          m_word valid
//  m_ready       in   1          sink accepts m_word
//  flush         in   1          sync abort of a partial fill/drain
//  busy          out  1          state != FILL or word count != 0
//  blocks_done   out  CNT_W      results fully drained; wraps at 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset (rst_n low, async): state=FILL, cnt=0, all data regs 0. s_ready=1; every other
//    output 0.
//  - Transfer on any interface = valid&ready at a clk rising edge. Once asserted, a valid
//    holds its data stable until the transfer.
//  - FILL: s_ready=1. Each transfer writes s_word to slot cnt; cnt++.
//    - Slot 0 is MSB: bits [BLK_W-1 -: WORD_W].
//    - Transfer with cnt==WORDS-1 -> SEND, cnt=0.
//    - aes_in_valid rises the cycle after the last word is accepted.
//  - SEND: s_ready=0, aes_in_valid=1, aes_in_block = packed register.
//    aes_in_ready -> WAIT; aes_in_valid drops the next cycle.
//  - WAIT: aes_out_ready=1; aes_out_valid -> capture aes_out_block, DRAIN, cnt=0.
//    aes_out_valid outside WAIT is ignored: aes_out_ready=0.
//  - DRAIN: m_valid=1, m_word = captured slot cnt (slot 0 = MSB). m_ready -> cnt++.
//    - Transfer with cnt==WORDS-1 -> FILL, cnt=0, blocks_done++.
//    - s_ready rises the cycle after the final word transfer.
//  - Latency with zero back-pressure:
//    - last input word -> aes_in_valid: 1 cycle
//    - result capture -> first m_valid: 1 cycle
//  - flush is sampled only in FILL and DRAIN; it is ignored in SEND and WAIT so the core
//    result is never orphaned.
//    - FILL: cnt=0, partial words discarded.
//    - DRAIN: remaining words discarded; -> FILL; blocks_done unchanged.
//    - flush has priority over a same-cycle s/m transfer; that word is dropped.
//  - Async reset mid-operation: return to the reset state immediately; an in-flight core
//    block is abandoned.
//  - busy = (state!=FILL) | (cnt!=0).
// TESTING
//  1 Words 00112233,44556677,8899aabb,ccddeeff with s_valid held, aes_in_ready=1 ->
//    aes_in_block=00112233_44556677_8899aabb_ccddeeff, aes_in_valid 1 cycle after 4th word.
//  2 Core model = FIPS-197 AES-128, key 000102..0f, on block 1 -> m_word sequence
//    69c4e0d8,6a7b0430,d8cdb780,70b4c55a; blocks_done=1; busy=0 afterwards.
//  3 Random s_valid/aes_in_ready/m_ready stall patterns, 50 blocks -> each word sequence
//    matches the model; no word lost or duplicated; valids hold data stable while stalled.
//  4 2 words, then flush, then 4 new words -> packed block holds only the 4 new words;
//    flush asserted in SEND/WAIT -> no effect.
//  5 rst_n pulsed low mid-DRAIN after word 1 -> m_valid=0, s_ready=1 asynchronously;
//    next full block processes correctly.
//  6 Preload blocks_done to 16'hffff via 65535 blocks, or force CNT_W=2 -> wraps to 0.

Source files
------------

// File: rtl/aes_block_gearbox.sv
// Word-serial gearbox: packs WORDS words into one block for the AES core, then replays the core result as words.
// Latency 1 cycle (last word -> aes_in_valid, capture -> m_valid); readies are state-only, one block in flight.
module aes_block_gearbox #(
   parameter int WORD_W = 32,
   parameter int WORDS  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WORD_W-1:0]         s_word,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [WORD_W*WORDS-1:0]   aes_in_block,
   output logic                      aes_in_valid,
   input  logic                      aes_in_ready,
   input  logic [WORD_W*WORDS-1:0]   aes_out_block,
   input  logic                      aes_out_valid,
   output logic                      aes_out_ready,
   output logic [WORD_W-1:0]         m_word,
   output logic                      m_valid,
   input  logic                      m_ready,
   input  logic                      flush,
   output logic                      busy,
   output logic [CNT_W-1:0]          blocks_done
);

   localparam int BLK_W = WORD_W * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {FILL, SEND, WAIT, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   cnt, cnt_nxt;
   logic [BLK_W-1:0]   in_blk, out_blk;
   logic [CNT_W-1:0]   done_cnt;
   logic               last, s_xfer, cap, done_inc;

   assign last   = (cnt == IDX_W'(WORDS - 1));
   // flush wins over a same-cycle input word, so that word never lands
   assign s_xfer = (state == FILL) & s_valid & ~flush;
   assign cap    = (state == WAIT) & aes_out_valid;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_inc  = 1'b0;
      case (state)
         FILL: begin
            if (flush) begin
               cnt_nxt = '0;
            end else if (s_valid) begin
               if (last) begin
                  state_nxt = SEND;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + IDX_W'(1);
               end
            end
         end
         SEND: begin
            if (aes_in_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (aes_out_valid) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end
         end
         DRAIN: begin
            if (flush) begin
               state_nxt = FILL;
               cnt_nxt   = '0;
            end else if (m_ready) begin
               if (last) begin
                  state_nxt = FILL;
                  cnt_nxt   = '0;
                  done_inc  = 1'b1;
               end else begin
                  cnt_nxt = cnt + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nxt = FILL;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // slot 0 is the most significant word of the block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_blk   <= '0;
         out_blk  <= '0;
         done_cnt <= '0;
      end else begin
         if (s_xfer) in_blk[(WORDS - 1 - int'(cnt)) * WORD_W +: WORD_W] <= s_word;
         if (cap) out_blk <= aes_out_block;
         if (done_inc) done_cnt <= done_cnt + CNT_W'(1);
      end
   end

   assign s_ready       = (state == FILL);
   assign aes_in_valid  = (state == SEND);
   assign aes_out_ready = (state == WAIT);
   assign m_valid       = (state == DRAIN);
   assign aes_in_block  = in_blk;
   assign m_word        = out_blk[(WORDS - 1 - int'(cnt)) * WORD_W +: WORD_W];
   assign busy          = (state != FILL) | (cnt != '0);
   assign blocks_done   = done_cnt;

endmodule
